fft_peak_hr_extract: RTL and testbench
======================================

// Module: fft_peak_hr_extract
// PURPOSE
//  Downstream of the LED1 FFT feed buffer. Consumes one FFT output frame
//  (fft_test sync_out/dout) per update.
//  - Computes |X|^2 per bin.
//  - Captures bin 0 as DC.
//  - Finds the largest bin inside the heart-rate search band; reports it
//    as AC and converts its index to beats/min.
//  Publishes AC/DC/HR with a one-cycle data-valid strobe to the UART/report stage.
// PARAMETERS
//  N_FFT        1024  bins per frame (sync-high cycles counted)
//  BIN_LO       80    first bin searched for HR peak (inclusive)
//  BIN_HI       480   last bin searched (inclusive); BIN_LO<=BIN_HI<N_FFT/2
//  BIN_BPM_Q8   128   bpm per bin, unsigned Q8 (128 = 0.5 bpm/bin)
//  MAG_SHIFT    13    right shift applied to 37-bit |X|^2 before 24-bit output
// PORTS
//  clk          in   1   system clock
//  rst          in   1   asynchronous, active-high reset
//  fft_sync     in   1   high while a frame's bins stream, one bin per cycle
//  fft_data     in   36  {re[35:18], im[17:0]}, both signed two's complement
//  AC_comp      out  24  peak in-band |X|^2 >> MAG_SHIFT, saturated
//  DC_comp      out  24  bin-0 |X|^2 >> MAG_SHIFT, saturated
//  HR           out  10  heart rate, bpm, saturated at 1023
//  new_comp_DV  out  1   one-cycle strobe: AC/DC/HR updated this cycle
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, bin counter 0, pipeline valid bits cleared.
//  Frame: a maximal run of consecutive fft_sync=1 cycles.
//  - Bin index is 0 on the first sync-high cycle, then increments per cycle.
//  - Cycles with index >= N_FFT in the same run are ignored.
//  - A run that ends (sync falls) before index N_FFT-1 aborts: no strobe,
//    outputs hold.
//  Pipeline (per bin):
//  - S1 registers |re|,|im| (18b unsigned; -2^17 maps to 2^17).
//  - S2 registers re^2+im^2 (37b unsigned, exact).
//  - S3 compares and updates.
//  FSM:
//  - IDLE: on fft_sync=1 -> ACCUM, idx=1 next; bin 0 enters pipe.
//  - ACCUM: idx++ each sync-high cycle.
//    -> DRAIN when idx==N_FFT-1 is accepted.
//    -> IDLE (abort, flush pipe) if sync=0 first.
//  - DRAIN: wait for last bin to exit S3, then -> OUT.
//  - OUT: latch outputs, pulse new_comp_DV one cycle.
//    -> IDLE; the next frame needs sync to fall then rise again.
//  Peak search: strict greater-than, so ties keep the lowest bin.
//  - Running max is seeded with value 0 at bin BIN_LO.
//  - An all-zero band reports bin BIN_LO with AC=0.
//  DC: mag of bin 0 captured in S3.
//  HR = (peak_bin*BIN_BPM_Q8 + 128) >> 8, rounded; >1023 -> 1023.
//  AC/DC: mag>>MAG_SHIFT; if result >= 2^24 -> 24'hFFFFFF.
//  Latency: new_comp_DV asserts 4 cycles after the clk edge sampling bin N_FFT-1.
//  Outputs hold between strobes; only OUT updates them.
//  Reset mid-frame discards everything; the first frame after reset must start
//  with a fresh sync rising edge.
//  sync already high when reset releases: that run is ignored until sync falls.
// CONFIGURATION
//  HR_AVG_EN defined: HR = mean of the last 4 valid-frame HR values.
//  - 4-deep history, sum>>2, truncating.
//  - History is zeroed at reset and primed by the first frame, which fills
//    all 4 slots.
//  - Aborted frames do not enter history.
//  HR_AVG_EN undefined: HR is the instantaneous per-frame value.
//  AC/DC are never averaged in either build.
// TESTING
//  1 Bin 200 = (1000,0), all other bins 0 -> AC=1000^2>>13=122, DC=0, HR=100,
//    DV exactly 4 cycles after bin 1023.
//  2 Bin 0 = (-131072,-131072), bin 300 = (4096,0) -> DC=4194304 (2^35>>13),
//    AC=2048, HR=150.
//  3 Equal peaks at bins 150 and 400 -> HR=75 (lowest bin wins);
//    peak at bin 79 only -> HR=40, AC=0.
//  4 Drop sync after 600 bins, then send a full frame with peak bin 240 ->
//    no DV for the short run; DV once with HR=120.
//  5 Assert rst at bin 500 -> outputs 0 immediately, no DV;
//    next full frame reports normally.
//  6 HR_AVG_EN: frames with peak bins 200,200,200,280 -> HR=100,100,100,110.

Source files
------------

// File: rtl/fft_peak_hr_extract.sv
// fft_peak_hr_extract - per-frame |X|^2 peak search giving AC/DC/HR with a data-valid strobe.
// Optional HR_AVG_EN: HR becomes the mean of the last four valid-frame values.
module fft_peak_hr_extract #(
  parameter int N_FFT      = 1024,
  parameter int BIN_LO     = 80,
  parameter int BIN_HI     = 480,
  parameter int BIN_BPM_Q8 = 128,
  parameter int MAG_SHIFT  = 13
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fft_sync,
  input  logic [35:0] fft_data,
  output logic [23:0] AC_comp,
  output logic [23:0] DC_comp,
  output logic [9:0]  HR,
  output logic        new_comp_DV
);

  localparam int IW = $clog2(N_FFT);
  localparam logic [IW-1:0] LAST_IDX = IW'(N_FFT - 1);
  localparam logic [IW-1:0] LO_IDX   = IW'(BIN_LO);
  localparam logic [IW-1:0] HI_IDX   = IW'(BIN_HI);

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, OUT} state_t;

  state_t        state_q;
  logic [IW-1:0] idx_q;
  logic          sync_prev_q;
  logic          v1_q, last1_q, v2_q, last2_q, s3_last_q;
  logic [IW-1:0] idx1_q, idx2_q;
  logic [17:0]   abs_re_q, abs_im_q;
  logic [36:0]   mag_q;
  logic [36:0]   max_q, dc_q;
  logic [IW-1:0] peak_bin_q;

  logic [17:0] re_d, im_d, abs_re_d, abs_im_d;
  logic [36:0] mag_d;
  logic [31:0] hr_prod_d, hr_shift_d;
  logic [9:0]  hr_inst_d, hr_out_d;
  logic [23:0] ac_d, dc_d;

  function automatic logic [23:0] sat24(input logic [36:0] m);
    logic [36:0] s;
    s = m >> MAG_SHIFT;
    return (s > 37'hFF_FFFF) ? 24'hFF_FFFF : s[23:0];
  endfunction

  // -2^17 negates to 2^17, which still fits the 18-bit unsigned magnitude
  always_comb begin
    re_d     = fft_data[35:18];
    im_d     = fft_data[17:0];
    abs_re_d = re_d[17] ? (~re_d + 18'd1) : re_d;
    abs_im_d = im_d[17] ? (~im_d + 18'd1) : im_d;
    mag_d    = 37'(abs_re_q) * 37'(abs_re_q) + 37'(abs_im_q) * 37'(abs_im_q);
    hr_prod_d  = 32'(peak_bin_q) * 32'(BIN_BPM_Q8) + 32'd128;
    hr_shift_d = hr_prod_d >> 8;
    hr_inst_d  = (hr_shift_d > 32'd1023) ? 10'd1023 : hr_shift_d[9:0];
    ac_d = sat24(max_q);
    dc_d = sat24(dc_q);
  end

`ifdef HR_AVG_EN
  logic [9:0]  hist0_q, hist1_q, hist2_q;
  logic        primed_q;
  logic [11:0] hr_sum_d;

  always_comb begin
    hr_sum_d = primed_q ? (12'(hr_inst_d) + 12'(hist0_q) + 12'(hist1_q) + 12'(hist2_q))
                        : {hr_inst_d, 2'b00};
    hr_out_d = hr_sum_d[11:2];
  end
`else
  always_comb hr_out_d = hr_inst_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      abs_re_q <= '0;
      abs_im_q <= '0;
      mag_q    <= '0;
    end else begin
      abs_re_q <= abs_re_d;
      abs_im_q <= abs_im_d;
      mag_q    <= mag_d;
    end
  end

  // sync_prev_q resets high so a run already in progress at reset release is ignored
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      sync_prev_q <= 1'b1;
      v1_q        <= 1'b0;
      last1_q     <= 1'b0;
      v2_q        <= 1'b0;
      last2_q     <= 1'b0;
      s3_last_q   <= 1'b0;
      idx1_q      <= '0;
      idx2_q      <= '0;
      max_q       <= '0;
      dc_q        <= '0;
      peak_bin_q  <= LO_IDX;
      AC_comp     <= '0;
      DC_comp     <= '0;
      HR          <= '0;
      new_comp_DV <= 1'b0;
`ifdef HR_AVG_EN
      hist0_q  <= '0;
      hist1_q  <= '0;
      hist2_q  <= '0;
      primed_q <= 1'b0;
`endif
    end else begin
      sync_prev_q <= fft_sync;
      new_comp_DV <= 1'b0;
      v1_q        <= 1'b0;
      last1_q     <= 1'b0;
      v2_q        <= v1_q;
      last2_q     <= last1_q;
      idx2_q      <= idx1_q;
      s3_last_q   <= v2_q && last2_q;
      if (v2_q) begin
        if (idx2_q == '0) dc_q <= mag_q;
        if (idx2_q >= LO_IDX && idx2_q <= HI_IDX && mag_q > max_q) begin
          max_q      <= mag_q;
          peak_bin_q <= idx2_q;
        end
      end
      case (state_q)
        IDLE: begin
          if (fft_sync && !sync_prev_q) begin
            v1_q       <= 1'b1;
            idx1_q     <= '0;
            idx_q      <= IW'(1);
            max_q      <= '0;
            dc_q       <= '0;
            peak_bin_q <= LO_IDX;
            state_q    <= ACCUM;
          end
        end
        ACCUM: begin
          if (fft_sync) begin
            v1_q   <= 1'b1;
            idx1_q <= idx_q;
            if (idx_q == LAST_IDX) begin
              last1_q <= 1'b1;
              state_q <= DRAIN;
            end else begin
              idx_q <= idx_q + IW'(1);
            end
          end else begin
            v2_q      <= 1'b0;
            s3_last_q <= 1'b0;
            state_q   <= IDLE;
          end
        end
        DRAIN: begin
          if (s3_last_q) state_q <= OUT;
        end
        OUT: begin
          AC_comp     <= ac_d;
          DC_comp     <= dc_d;
          HR          <= hr_out_d;
          new_comp_DV <= 1'b1;
          state_q     <= IDLE;
`ifdef HR_AVG_EN
          if (primed_q) begin
            hist2_q <= hist1_q;
            hist1_q <= hist0_q;
          end else begin
            hist2_q <= hr_inst_d;
            hist1_q <= hr_inst_d;
          end
          hist0_q  <= hr_inst_d;
          primed_q <= 1'b1;
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_peak_hr_extract.sv
// tb/tb_fft_peak_hr_extract.sv - directed frame vectors for fft_peak_hr_extract.
module tb_fft_peak_hr_extract;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fft_sync = 1'b0;
  logic [35:0] fft_data = '0;
  logic [23:0] AC_comp, DC_comp;
  logic [9:0]  HR;
  logic        new_comp_DV;

  fft_peak_hr_extract dut (
    .clk(clk), .rst(rst), .fft_sync(fft_sync), .fft_data(fft_data),
    .AC_comp(AC_comp), .DC_comp(DC_comp), .HR(HR), .new_comp_DV(new_comp_DV)
  );

  always #5 clk = ~clk;

  typedef struct {
    int nb;
    int b0, r0, i0;
    int b1, r1, i1;
    int ac, dc, hr;
  } vec_t;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_cyc = -100;
  int dv_count = 0;
  int dv_cyc = -1000;
  int dv_ac, dv_dc, dv_hr;
  int last_ac, last_dc, last_hr;

`ifdef HR_AVG_EN
  int mh0, mh1, mh2;
  bit mprimed = 1'b0;
`endif

  always @(posedge clk) cyc = cyc + 1;

  always @(negedge clk) begin
    if (new_comp_DV) begin
      dv_count = dv_count + 1;
      dv_cyc   = cyc;
      dv_ac    = int'(AC_comp);
      dv_dc    = int'(DC_comp);
      dv_hr    = int'(HR);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks = checks + 1;
    if (act != exp) begin
      failures = failures + 1;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic update_model(input int inst, output int e);
`ifdef HR_AVG_EN
    if (!mprimed) begin
      e = inst;
      mh0 = inst; mh1 = inst; mh2 = inst;
      mprimed = 1'b1;
    end else begin
      e = (inst + mh0 + mh1 + mh2) / 4;
      mh2 = mh1; mh1 = mh0; mh0 = inst;
    end
`else
    e = inst;
`endif
  endtask

  task automatic reset_model();
`ifdef HR_AVG_EN
    mprimed = 1'b0;
`endif
  endtask

  function automatic logic [35:0] bin_val(input vec_t v, input int k);
    int tr, ti;
    logic [31:0] ur, ui;
    tr = 0; ti = 0;
    if (k == v.b0) begin tr = v.r0; ti = v.i0; end
    if (k == v.b1) begin tr = v.r1; ti = v.i1; end
    ur = tr; ui = ti;
    return {ur[17:0], ui[17:0]};
  endfunction

  task automatic send_frame(input vec_t v);
    for (int k = 0; k < v.nb; k++) begin
      @(negedge clk);
      fft_sync = 1'b1;
      fft_data = bin_val(v, k);
      if (k == 1023) begin
        @(posedge clk);
        #1 last_cyc = cyc;
      end
    end
    @(negedge clk);
    fft_sync = 1'b0;
    fft_data = '0;
  endtask

  task automatic run_vec(input string name, input vec_t v, input int exp_hr);
    dv_count = 0;
    send_frame(v);
    repeat (10) @(negedge clk);
    chk({name, "_dv_count"}, dv_count, 1);
    chk({name, "_latency"}, dv_cyc - last_cyc, 4);
    chk({name, "_ac"}, dv_ac, v.ac);
    chk({name, "_dc"}, dv_dc, v.dc);
    chk({name, "_hr"}, dv_hr, exp_hr);
    last_ac = v.ac; last_dc = v.dc; last_hr = exp_hr;
  endtask

  vec_t vecs[8];
  vec_t v_abort, v240, v_rst;
  vec_t v6[4];
  int   exp6[4];
  int   e;

  initial begin
    vecs[0] = '{1024, 200, 1000, 0, -1, 0, 0, 122, 0, 100};
    vecs[1] = '{1024, 0, -131072, -131072, 300, 4096, 0, 2048, 4194304, 150};
    vecs[2] = '{1024, 150, 1000, 0, 400, 1000, 0, 122, 0, 75};
    vecs[3] = '{1024, 79, 5000, 0, -1, 0, 0, 0, 0, 40};
    vecs[4] = '{1024, 480, 0, -3000, -1, 0, 0, 1098, 0, 240};
    vecs[5] = '{1024, 481, 0, 9000, 80, 10, 0, 0, 0, 40};
    vecs[6] = '{1024, 0, 100, -100, 80, -3000, 4000, 3051, 2, 40};
    vecs[7] = '{1100, 333, 2000, 0, -1, 0, 0, 488, 0, 167};
    v_abort = '{600, 240, 1000, 0, -1, 0, 0, 0, 0, 0};
    v240    = '{1024, 240, 1000, 0, -1, 0, 0, 122, 0, 120};
    v_rst   = '{1024, 200, 1000, 0, -1, 0, 0, 0, 0, 0};
    v6[0] = '{1024, 200, 1000, 0, -1, 0, 0, 122, 0, 100};
    v6[1] = v6[0];
    v6[2] = v6[0];
    v6[3] = '{1024, 280, 1000, 0, -1, 0, 0, 122, 0, 140};
`ifdef HR_AVG_EN
    exp6 = '{100, 100, 100, 110};
`else
    exp6 = '{100, 100, 100, 140};
`endif

    // reset state
    repeat (3) @(negedge clk);
    #1;
    chk("reset_ac", int'(AC_comp), 0);
    chk("reset_dc", int'(DC_comp), 0);
    chk("reset_hr", int'(HR), 0);
    chk("reset_dv", int'(new_comp_DV), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      update_model(vecs[i].hr, e);
      run_vec($sformatf("vec%0d", i), vecs[i], e);
    end

    // short run aborts and outputs hold
    dv_count = 0;
    send_frame(v_abort);
    repeat (10) @(negedge clk);
    chk("abort_no_dv", dv_count, 0);
    chk("abort_hold_ac", int'(AC_comp), last_ac);
    chk("abort_hold_hr", int'(HR), last_hr);
    update_model(v240.hr, e);
    run_vec("after_abort", v240, e);

    // reset mid-frame, sync still high on release
    dv_count = 0;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      fft_sync = 1'b1;
      fft_data = bin_val(v_rst, k);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_ac", int'(AC_comp), 0);
    chk("midrst_dc", int'(DC_comp), 0);
    chk("midrst_hr", int'(HR), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 1100; k++) begin
      @(negedge clk);
      fft_data = bin_val(v_rst, k);
    end
    @(negedge clk);
    fft_sync = 1'b0;
    fft_data = '0;
    repeat (10) @(negedge clk);
    chk("midrst_no_dv", dv_count, 0);
    reset_model();
    update_model(v240.hr, e);
    run_vec("after_rst", v240, e);

    // history sequence from a clean reset
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    reset_model();
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      run_vec($sformatf("hist%0d", i), v6[i], exp6[i]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
